// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, Booth encodings and counter sizing for booth_seq_mult
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
  function automatic int cnt_w(int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand request and product response bundle of the Booth multiplier
interface booth_seq_mult_if #(parameter int N = 8);
  logic start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic busy;
  logic done;
  logic [2*N-1:0] product;
  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/subtract/no-op on the N+1-bit partial remainder
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N:0]   mx,
  input  logic [1:0]   op,
  output logic [N:0]   a_next
);
  // subtract as A + ~Mx + 1; carry-out falls off the N+1-bit result
  always_comb a_next = (op == ADD) ? a + mx : (op == SUB) ? a + ~mx + (N+1)'(1) : a;
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier, N+1 cycles per product (BOOTH_ZERO_BYPASS_EN skips zero operands)
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input logic clk,
  input logic rst_n,
  booth_seq_mult_if.slave bus
);
  localparam int CW = cnt_w(N);
  state_t state;
  logic [N:0] a, mx, a_n, a_s;
  logic [N-1:0] q, q_s;
  logic q1;
  logic [CW-1:0] cnt;
  logic zero_op;
  booth_step #(.N(N)) u_step (.a(a), .mx(mx), .op({q[0], q1}), .a_next(a_n));
  assign a_s = {a_n[N], a_n[N:1]};
  assign q_s = {a_n[0], q[N-1:1]};
`ifdef BOOTH_ZERO_BYPASS_EN
  assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif
  // FSM: load operands, run N add/shift steps, then publish the product for one done cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      mx <= '0;
      q <= '0;
      q1 <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.product <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a <= '0;
            mx <= {bus.multiplicand[N-1], bus.multiplicand};
            q <= bus.multiplier;
            q1 <= 1'b0;
            cnt <= CW'(N-1);
            bus.busy <= 1'b1;
            if (zero_op) begin
              state <= DONE;
              bus.done <= 1'b1;
              bus.product <= '0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          a <= a_s;
          q <= q_s;
          q1 <= q[0];
          cnt <= (cnt == '0) ? cnt : cnt - CW'(1);
          if (cnt == '0) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.product <= {a_s[N-1:0], q_s};
          end
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: randomized and directed scoreboard bench for booth_seq_mult
module tb_booth_seq_mult;
  localparam int N = 8;
  typedef struct {
    logic [2*N-1:0] prod;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];
  booth_seq_mult_if #(.N(N)) bus ();
  booth_seq_mult #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [2*N-1:0] ref_mul(logic [N-1:0] m, logic [N-1:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p[2*N-1:0];
  endfunction
  function automatic int ref_lat(logic [N-1:0] m, logic [N-1:0] q);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (m == 0 || q == 0) return 1;
`endif
    return N + 1;
  endfunction
  task automatic check(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic do_op(logic [N-1:0] m, logic [N-1:0] q, bit expect_it, output int stamp);
    int t = 0;
    while (bus.busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", t, 0);
    bus.start = 1'b1;
    bus.multiplicand = m;
    bus.multiplier = q;
    stamp = cyc;
    if (expect_it) sb.push_back('{ref_mul(m, q), cyc + ref_lat(m, q)});
    @(negedge clk);
    bus.start = 1'b0;
    bus.multiplicand = N'($urandom);
    bus.multiplier = N'($urandom);
    check("busy_after_start", bus.busy, 1);
  endtask
  task automatic pulse_start(logic [N-1:0] m, logic [N-1:0] q);
    bus.start = 1'b1;
    bus.multiplicand = m;
    bus.multiplier = q;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // scoreboard monitor: every done pulse must match the oldest outstanding product and its due cycle
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: product %0h at cycle %0d, none outstanding", bus.product, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", bus.product, e.prod);
        check("done_cycle", cyc, e.due);
        check("busy_in_done", bus.busy, 1);
      end
    end
  end
  initial begin
    int s;
    int t;
    logic [N-1:0] m, q;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_product", bus.product, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'd3, 8'd5, 1, s);
    wait_to(s + N + 2);
    check("3x5_busy_low", bus.busy, 0);
    check("3x5_product", bus.product, 16'd15);
    do_op(8'h80, 8'h80, 1, s);
    wait_to(s + N + 2);
    check("m128xm128", bus.product, 16'h4000);
    do_op(8'h80, 8'h7f, 1, s);
    wait_to(s + N + 2);
    check("m128x127", bus.product, 16'hC080);
    do_op(8'd7, 8'hff, 1, s);
    wait_to(s + 3);
    pulse_start(8'd5, 8'd5);
    wait_to(s + N + 1);
    pulse_start(8'd9, 8'd9);
    check("start_in_done_ignored", bus.busy, 0);
    check("7xm1_held", bus.product, 16'hFFF9);
    do_op(8'd2, 8'd2, 1, s);
    check("accept_at_n_plus_2", s, s);
    wait_to(s + N + 2);
    do_op(8'd25, 8'd25, 0, s);
    wait_to(s + 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", bus.busy, 0);
    check("midreset_product", bus.product, 0);
    check("midreset_done", bus.done, 0);
    do_op(8'd2, 8'd3, 1, s);
    wait_to(s + N + 2);
    check("2x3", bus.product, 16'd6);
    do_op(8'd0, 8'd77, 1, s);
    wait_to(s + ref_lat(8'd0, 8'd77) + 1);
    check("0x77_product", bus.product, 0);
    check("0x77_idle", bus.busy, 0);
    for (int i = 0; i < 40; i++) begin
      m = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      q = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      do_op(m, q, 1, s);
    end
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (N + 4) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  // hard ceiling so a stuck DUT still ends in a summary
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: run exceeded time limit at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-2 Booth signed multiplier for the MACC datapath. Each iteration it drives one N+1-bit add/subtract step and then an arithmetic right shift. It sits directly upstream of the MACC accumulator and feeds it a 2N-bit signed product. It trades area for latency: one adder and N+1 cycles per product.

## Interface
- `N`, 8: operand width in bits, two's complement; N ≥ 2.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset; one clock; reset is synchronous and active-low.
- `start`, input, 1: request a multiplication; sampled only in IDLE.
- `multiplicand`, input, N: signed operand M; captured with `start`.
- `multiplier`, input, N: signed operand Q; captured with `start`.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle pulse, high while in DONE.
- `product`, output, 2N: signed M×Q; valid from the `done` cycle; held until the next accepted `start` or reset.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE, `start`=1:**
  - Load A=0 (N+1 bits).
  - Load Mx = sign-extended M (N+1 bits).
  - Load Q = multiplier, q₋₁=0, cnt=N−1.
  - Go to CALC.
- **CALC, each cycle:**
  - Examine {Q[0], q₋₁}.
  - 01: A = A+Mx.
  - 10: A = A−Mx, formed as A + ~Mx + 1 with carry-in 1.
  - 00/11: A unchanged.
  - Then arithmetic-shift {A,Q,q₋₁} right by 1; the MSB of A is replicated.
  - The adder output is N+1 bits; carry-out is discarded.
  - The N+1-bit A holds M = −2^(N−1) without overflow.
  - If cnt=0, go to DONE; else decrement cnt.
- **DONE:**
  - `product` = {A[N−1:0], Q}, the low 2N bits of {A,Q}.
  - `done`=1.
  - Next state is IDLE unconditionally.
- `start` while `busy`=1 is ignored. It is not queued, and operands are not re-sampled.
- `start` in the DONE cycle is ignored; a new operation is accepted from IDLE only.
- Reset mid-operation: state goes to IDLE next cycle and all internal registers clear.
- Reset values:
  - `busy`=0, `done`=0, `product`=0.
  - A, Q, q₋₁, Mx, cnt all 0.
- Operand inputs are don't-care outside the `start` cycle in IDLE.

## Timing
- Cycle 0: `start`=1 sampled in IDLE.
- Cycles 1..N: CALC, `busy`=1.
- Cycle N+1: DONE, `busy`=1, `done`=1, `product` valid.
- Cycle N+2: IDLE, `busy`=0; the earliest new `start` is sampled here.
- Throughput: one product per N+2 cycles.
- `product` is registered and updates only on the DONE transition. It stays stable from cycle N+1 onward.
- One adder evaluation per CALC cycle; the critical path is the N+1-bit ripple chain plus the shift mux.

## Configuration
- `BOOTH_ZERO_BYPASS_EN`
  - **Defined:** in IDLE with `start`=1 and either operand equal to 0, go directly to DONE with `product`=0.
    - `done` fires in cycle 1; `busy` is high in cycle 1 only.
    - Non-zero operands behave exactly as without the macro.
  - **Undefined:** every operation takes the full N+1 cycles, including zero operands.

## Structure
- Package `booth_pkg`:
  - State enum {IDLE, CALC, DONE}.
  - Counter width `$clog2(N)` helper.
  - Booth encoding constants: ADD=2'b01, SUB=2'b10.
- Sub-module `booth_step`:
  - Purely combinational, N+1 bits.
  - Inputs: A, Mx, {Q[0], q₋₁}.
  - Output: next A after add/sub/no-op.
  - The top level owns the shift, counter and FSM.

## Test plan
- 3 × 5, N=8: `start` at cycle 0 → `done` at cycle 9, `product`=16'd15, `busy` low at cycle 10.
- −128 × −128 → `product`=16'd16384 (0x4000).
- −128 × 127 → `product`=0xC080 (−16256).
- 7 × −1 → 0xFFF9 (−7); `start` pulsed again at cycles 3 and 9 (busy and DONE) → ignored; product unchanged; next op accepted only at cycle 10.
- 25 × 25 with `rst_n`=0 at cycle 4 → cycle 5 `busy`=0 and `product`=0; no `done` pulse; a following 2×3 yields 6.
- 0 × 77 → with `BOOTH_ZERO_BYPASS_EN`, `done` at cycle 1 and `product`=0; without it, `done` at cycle 9 and `product`=0.
